// File: rtl/cpe_mem_pkg.sv
// cpe_mem_pkg: shared funct3 encodings, FSM states, strobes and store/alignment helpers
package cpe_mem_pkg;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [3:0] STRB_NONE = 4'b0000;
  localparam logic [3:0] STRB_B    = 4'b0001;
  localparam logic [3:0] STRB_H    = 4'b0011;
  localparam logic [3:0] STRB_W    = 4'b1111;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;
  function automatic logic f3_legal(input logic ld, input logic [2:0] f3);
    return ld ? (f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU}) : (f3 inside {F3_SB, F3_SH, F3_SW});
  endfunction
  function automatic logic f3_aligned(input logic [2:0] f3, input logic [1:0] lo);
    return f3[1:0] == 2'b01 ? !lo[0] : f3[1:0] == 2'b10 ? lo == 2'b00 : 1'b1;
  endfunction
  function automatic logic [3:0] st_strb(input logic [2:0] f3, input logic [1:0] lo);
    return f3 == F3_SB ? STRB_B << lo : f3 == F3_SH ? STRB_H << {lo[1], 1'b0} : STRB_W;
  endfunction
  function automatic logic [31:0] st_data(input logic [2:0] f3, input logic [31:0] d);
    return f3 == F3_SB ? {4{d[7:0]}} : f3 == F3_SH ? {2{d[15:0]}} : d;
  endfunction
endpackage

// File: rtl/mem_load_ext.sv
// mem_load_ext: lane select and sign/zero extension of bus read data
module mem_load_ext
  import cpe_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lo2,
  input  logic [31:0] rdata,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = lo2 == 2'd0 ? rdata[7:0] : lo2 == 2'd1 ? rdata[15:8] : lo2 == 2'd2 ? rdata[23:16] : rdata[31:24];
    h = lo2[1] ? rdata[31:16] : rdata[15:0];
    data = funct3 == F3_LB  ? {{24{b[7]}}, b} :
           funct3 == F3_LBU ? {24'd0, b} :
           funct3 == F3_LH  ? {{16{h[15]}}, h} :
           funct3 == F3_LHU ? {16'd0, h} : rdata;
  end
endmodule

// File: rtl/data_mem_if.sv
// data_mem_if: CPU load/store to single-outstanding bus bridge with alignment checks and timeout
module data_mem_if
  import cpe_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_w_i,
  input  logic        res_w_i_h,
  input  logic        cpu_rd_w_i_h,
  input  logic        cpu_wr_w_i_h,
  input  logic [31:0] cpu_addr_w_i,
  input  logic [31:0] cpu_wdata_w_i,
  input  logic [2:0]  cpu_funct3_w_i,
  output logic [31:0] cpu_rdata_w_o,
  output logic        cpu_stall_w_o_h,
  output logic        cpu_err_w_o_h,
  output logic        bus_req_w_o_h,
  output logic        bus_we_w_o_h,
  output logic [31:0] bus_addr_w_o,
  output logic [31:0] bus_wdata_w_o,
  output logic [3:0]  bus_strb_w_o,
  input  logic        bus_ack_w_i_h,
  input  logic [31:0] bus_rdata_w_i
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [2:0] f3_q;
  logic [1:0] lo2_q;
  logic to_q, ok, bad, tmo;
  logic [31:0] ld_ext;
  mem_load_ext u_ext (
    .funct3(f3_q),
    .lo2(lo2_q),
    .rdata(bus_rdata_w_i),
    .data(ld_ext)
  );
  always_comb begin
    ok = (cpu_rd_w_i_h ^ cpu_wr_w_i_h) && f3_legal(cpu_rd_w_i_h, cpu_funct3_w_i) && f3_aligned(cpu_funct3_w_i, cpu_addr_w_i[1:0]);
    bad = (cpu_rd_w_i_h | cpu_wr_w_i_h) && !ok;
    tmo = state == S_REQ && !bus_ack_w_i_h && cnt == CW'(TIMEOUT_CYCLES - 1);
  end
  always_ff @(posedge clk_w_i or posedge res_w_i_h)
    if (res_w_i_h) state <= S_IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == S_IDLE ? (ok ? S_REQ : S_IDLE) :
               state == S_REQ  ? (bus_ack_w_i_h || tmo ? S_DONE : S_REQ) : S_IDLE;
  // reset must silence the combinational outputs too, not just the registers
  always_comb begin
    cpu_stall_w_o_h = !res_w_i_h && (state == S_REQ || (state == S_IDLE && ok));
    cpu_err_w_o_h = !res_w_i_h && ((state == S_IDLE && bad) || (state == S_DONE && to_q));
  end
  always_ff @(posedge clk_w_i or posedge res_w_i_h)
    if (res_w_i_h) begin
      bus_req_w_o_h <= 1'b0;
      bus_we_w_o_h <= 1'b0;
      bus_addr_w_o <= '0;
      bus_wdata_w_o <= '0;
      bus_strb_w_o <= STRB_NONE;
      cpu_rdata_w_o <= '0;
      cnt <= '0;
      f3_q <= '0;
      lo2_q <= '0;
      to_q <= 1'b0;
    end else begin
      if (state == S_IDLE && ok) begin
        bus_req_w_o_h <= 1'b1;
        bus_we_w_o_h <= cpu_wr_w_i_h;
        bus_addr_w_o <= {cpu_addr_w_i[31:2], 2'b00};
        bus_wdata_w_o <= st_data(cpu_funct3_w_i, cpu_wdata_w_i);
        bus_strb_w_o <= cpu_wr_w_i_h ? st_strb(cpu_funct3_w_i, cpu_addr_w_i[1:0]) : STRB_NONE;
        cnt <= '0;
        f3_q <= cpu_funct3_w_i;
        lo2_q <= cpu_addr_w_i[1:0];
      end else if (state == S_IDLE && bad) cpu_rdata_w_o <= '0;
      if (state == S_REQ) begin
        if (bus_ack_w_i_h) begin
          bus_req_w_o_h <= 1'b0;
          if (!bus_we_w_o_h) cpu_rdata_w_o <= ld_ext;
        end else begin
          cnt <= cnt + 1'b1;
          if (tmo) begin
            bus_req_w_o_h <= 1'b0;
            cpu_rdata_w_o <= '0;
            to_q <= 1'b1;
          end
        end
      end
      if (state == S_DONE) to_q <= 1'b0;
    end
endmodule

// File: doc/data_mem_if.md
DATA_MEM_IF -- requirements
Module: data_mem_if

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum cycles spent waiting for bus_ack_w_i_h before aborting an access.
REQ-002 clk_w_i  in  1  single clock; all state updates on its rising edge.
REQ-003 res_w_i_h  in  1  reset, asynchronous, active-high.
REQ-004 cpu_rd_w_i_h  in  1  load request from the CPU datapath.
REQ-005 cpu_wr_w_i_h  in  1  store request from the CPU datapath.
REQ-006 cpu_addr_w_i  in  32  byte address, taken from the ALU result.
REQ-007 cpu_wdata_w_i  in  32  store data, taken from rs2.
REQ-008 cpu_funct3_w_i  in  3  instr[14:12], the access size and sign.
REQ-009 cpu_rdata_w_o  out  32  extended load data, registered.
REQ-010 cpu_stall_w_o_h  out  1  holds the CPU PC and register write.
REQ-011 cpu_err_w_o_h  out  1  one-cycle pulse; the access was misaligned, illegal or timed out.
REQ-012 bus_req_w_o_h  out  1  bus request, registered.
REQ-013 bus_we_w_o_h  out  1  bus write enable.
REQ-014 bus_addr_w_o  out  32  word address, {addr[31:2],2'b00}.
REQ-015 bus_wdata_w_o  out  32  lane-positioned store data.
REQ-016 bus_strb_w_o  out  4  byte-lane write strobes.
REQ-017 bus_ack_w_i_h  in  1  bus completion strobe.
REQ-018 bus_rdata_w_i  in  32  bus read data, valid while bus_ack_w_i_h is high.

Function
REQ-019 The FSM SHALL have exactly three states, IDLE, REQ and DONE, and SHALL reset to IDLE.
REQ-020 A request is valid in IDLE when exactly one of cpu_rd_w_i_h or cpu_wr_w_i_h is high.
REQ-021 A request is legal when funct3 is one of the following:
- loads: 000, 001, 010, 100, 101
- stores: 000, 001, 010
REQ-022 Alignment rules for a legal request:
- halfword: addr[0] SHALL be 0
- word: addr[1:0] SHALL be 00
REQ-023 Valid, legal, aligned request in IDLE: cpu_stall_w_o_h SHALL be high combinationally in that cycle; bus outputs are registered and the FSM moves to REQ.
REQ-024 Valid but illegal or misaligned request in IDLE:
- no bus access
- cpu_err_w_o_h high and cpu_stall_w_o_h low in the same cycle
- cpu_rdata_w_o cleared to 0 at the next edge
- FSM stays in IDLE
REQ-025 Both rd and wr high in IDLE SHALL be treated as illegal, per REQ-024.
REQ-026 In REQ, stall and bus_req SHALL stay high, and addr, we, wdata and strb SHALL stay stable until ack.
REQ-027 On ack in REQ:
- drop bus_req at the next edge
- register the extended load data (stores leave cpu_rdata_w_o unchanged)
- go to DONE
REQ-028 DONE SHALL last exactly one cycle with stall low, and SHALL ignore the CPU request inputs, then return to IDLE.
REQ-029 Minimum latency is 3 cycles (IDLE, REQ with ack, DONE); each extra wait cycle adds one.
REQ-030 The timeout counter SHALL clear on entry to REQ and increment each REQ cycle without ack.
REQ-031 When the counter reaches TIMEOUT_CYCLES:
- drop bus_req
- cpu_rdata_w_o = 0
- cpu_err_w_o_h pulses in the DONE cycle
- go to DONE
REQ-032 An ack arriving in IDLE or DONE SHALL be ignored.
REQ-033 Load extension, using addr[1:0] to select the lane:
- LB/LBU: byte lane addr[1:0], sign- or zero-extended
- LH/LHU: halfword lane addr[1], sign- or zero-extended
- LW: full word
REQ-034 Store positioning:
- SB: strb = 4'b0001 << addr[1:0], byte replicated into all four lanes
- SH: strb = 4'b0011 << (2*addr[1]), halfword replicated into both halves
- SW: strb = 4'b1111, data unchanged
REQ-035 For loads, bus_strb_w_o SHALL be 4'b0000 and bus_we_w_o_h SHALL be low.

Reset
REQ-036 Asserting res_w_i_h SHALL immediately, without a clock:
- force IDLE
- set bus_req, bus_we, stall and err low
- set bus_addr, bus_wdata, bus_strb and cpu_rdata to 0
- clear the timeout counter
REQ-037 Reset in the middle of a transfer SHALL abandon it; a late ack after reset is ignored per REQ-032.

Structure
REQ-038 Shared package cpe_mem_pkg SHALL hold:
- funct3 encodings (LB, LH, LW, LBU, LHU, SB, SH, SW)
- the FSM state encoding
- strobe constants
REQ-039 Lane select and sign/zero extension SHALL be one combinational sub-module, mem_load_ext.

Verification
REQ-040 LB from addr 0x103, bus_rdata 0x80FF_1234, ack in the first REQ cycle:
- cpu_rdata_w_o = 0xFFFF_FF80
- stall high for 2 cycles, then DONE
REQ-041 SH to addr 0x102, data 0x0000_BEEF:
- strb = 4'b1100, bus_wdata = 0xBEEF_BEEF, bus_addr = 0x100
- all held stable across 3 wait cycles until ack
REQ-042 LW at addr 0x101: err pulse with stall low in the same cycle, bus_req never rises, cpu_rdata_w_o = 0.
REQ-043 TIMEOUT_CYCLES = 4 with no ack: bus_req drops after 4 REQ cycles, err pulses in DONE, cpu_rdata_w_o = 0.
REQ-044 Reset asserted in the 2nd REQ cycle, then an ack 1 cycle later:
- all outputs 0 immediately
- FSM in IDLE
- the ack is ignored
REQ-045 LHU from addr 0x102 with 0x8001_0000 returns 0x0000_8001; funct3 011 with rd high returns err and no bus access.
